// File: rtl/trigger_event_collector.sv
// Collects rising-edge events into a sticky pending mask and emits rate-limited
// one-cycle trigger pulses; counts events lost while their bit was already pending.
module trigger_event_collector #(
  parameter int unsigned N       = 16,
  parameter int unsigned HOLDOFF = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ev_in,
  input  logic [N-1:0]     ev_mask,
  input  logic [N-1:0]     ack,
  input  logic             clr_drop,
  output logic [N-1:0]     trig_out,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
  localparam int unsigned SW = CNT_W + $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_HOLD
  } state_e;

  state_e          state_q;
  logic [HW-1:0]   hold_cnt_q;
  logic [N-1:0]    ev_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    sent_q, sent_d;
  logic [N-1:0]    trig_q;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [N-1:0]    edge_det;
  logic [N-1:0]    drops;
  logic [N-1:0]    new_bits;
  logic [N-1:0]    emit_bits;
  logic [SW-1:0]   drop_sum;

  always_comb begin
    edge_det  = ev_in & ~ev_q & ev_mask;
    drops     = edge_det & pending_q & ~ack;
    pending_d = edge_det | (pending_q & ~ack);
    new_bits  = pending_q & ~sent_q;
    emit_bits = (state_q == ST_IDLE) ? new_bits : '0;
    // A fresh edge re-arms the bit; an emit in the same cycle still marks it sent.
    sent_d    = (sent_q & ~(ack | edge_det)) | emit_bits;

    drop_sum = SW'(drop_q);
    for (int unsigned i = 0; i < N; i++) begin
      drop_sum = drop_sum + SW'(drops[i]);
    end
    if (clr_drop) begin
      drop_d = '0;
    end else if (drop_sum > SW'({CNT_W{1'b1}})) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      ev_q       <= '0;
      pending_q  <= '0;
      sent_q     <= '0;
      trig_q     <= '0;
      drop_q     <= '0;
    end else begin
      ev_q      <= ev_in;
      pending_q <= pending_d;
      sent_q    <= sent_d;
      drop_q    <= drop_d;
      case (state_q)
        ST_IDLE: begin
          trig_q <= emit_bits;
          if (|emit_bits) begin
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          trig_q <= '0;
          if (HOLDOFF == 0) begin
            state_q <= ST_IDLE;
          end else begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          trig_q <= '0;
          if (hold_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: begin
          trig_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign trig_out   = trig_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trigger_event_collector.sv
// Directed bench: stimulus queues expected trigger pulses, a negedge monitor checks them.
module tb_trigger_event_collector;

  localparam int unsigned N       = 16;
  localparam int unsigned HOLDOFF = 4;
  localparam int unsigned CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     ev_in, ev_mask, ack;
  logic             clr_drop;
  logic [N-1:0]     trig_out, pending;
  logic [CNT_W-1:0] drop_count;
  logic             busy;

  always #5 clk = ~clk;

  trigger_event_collector #(
    .N      (N),
    .HOLDOFF(HOLDOFF),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ev_in     (ev_in),
    .ev_mask   (ev_mask),
    .ack       (ack),
    .clr_drop  (clr_drop),
    .trig_out  (trig_out),
    .pending   (pending),
    .drop_count(drop_count),
    .busy      (busy)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] val;
    int unsigned  at;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [N-1:0] v, input int unsigned at);
    sbq.push_back(exp_t'{v, at});
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every nonzero trig_out must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (trig_out != '0) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: trig_out=0x%0h but none expected, cycle %0d", trig_out, cyc);
      end else begin
        e = sbq.pop_front();
        chk("trig_val", 32'(trig_out), 32'(e.val));
        chk("trig_cycle", cyc, e.at);
      end
    end else if (sbq.size() != 0 && sbq[0].at < cyc) begin
      e = sbq.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_pulse: got none expected 0x%0h at cycle %0d", e.val, e.at);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ev_in = 16'h0001; ev_mask = '1; ack = '0; clr_drop = 1'b0;
    tick(3);
    chk("rst_trig", 32'(trig_out), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: level held through reset release counts as one edge
    reset = 1'b0;
    expect_pulse(16'h0001, cyc + 2);
    tick(1);
    chk("t1_pending", 32'(pending), 32'h1);
    tick(7);
    chk("t1_pending_hold", 32'(pending), 32'h1);
    chk("t1_busy_idle", 32'(busy), 0);
    ack = 16'h0001;
    tick(1);
    ack = '0;
    chk("t1_pending_ack", 32'(pending), 0);
    ev_in = '0;
    tick(2);

    // 2: single edge, late ack
    ev_in = 16'h0008;
    expect_pulse(16'h0008, cyc + 2);
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      if (i == 1) ev_in = '0;
      if (i == 10) ack = 16'h0008;
      if (i == 11) ack = '0;
      chk("t2_pending", 32'(pending), (i <= 10) ? 32'h8 : 32'h0);
    end
    tick(3);

    // 4: second event held off by HOLDOFF
    ev_in = 16'h0002;
    expect_pulse(16'h0002, cyc + 2);
    chk("t4_busy_pre", 32'(busy), 0);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 1) ev_in = '0;
      if (i == 2) begin
        ev_in = 16'h0004;
        expect_pulse(16'h0004, cyc + 6);
      end
      if (i == 3) ev_in = '0;
      if (i == 1) chk("t4_busy", 32'(busy), 0);
      if (i >= 2 && i <= 6) chk("t4_busy", 32'(busy), 1);
      if (i == 8) chk("t4_busy", 32'(busy), 1);
    end
    tick(6);
    ack = 16'h0006;
    tick(1);
    ack = '0;
    chk("t4_pending_ack", 32'(pending), 0);

    // 3: drop counting and saturation; each re-edge re-arms a pulse
    for (int k = 0; k < 258; k++) begin
      ev_in = 16'h0001;
      expect_pulse(16'h0001, cyc + 2);
      tick(1);
      ev_in = '0;
      tick(5);
      if (k == 1)   chk("t3_drop_1", 32'(drop_count), 1);
      if (k == 254) chk("t3_drop_254", 32'(drop_count), 254);
      if (k == 257) chk("t3_drop_sat", 32'(drop_count), 255);
    end
    tick(2);
    chk("t3_drop_sat_hold", 32'(drop_count), 255);
    clr_drop = 1'b1;
    tick(1);
    clr_drop = 1'b0;
    chk("t3_drop_clr", 32'(drop_count), 0);
    ack = 16'h0001;
    tick(1);
    ack = '0;
    chk("t3_pending_ack", 32'(pending), 0);
    tick(2);

    // 5: edge and ack together on a sent bit
    ev_in = 16'h0020;
    expect_pulse(16'h0020, cyc + 2);
    tick(1);
    ev_in = '0;
    tick(9);
    chk("t5_pending_sent", 32'(pending), 32'h20);
    ev_in = 16'h0020;
    ack   = 16'h0020;
    expect_pulse(16'h0020, cyc + 2);
    tick(1);
    ev_in = '0;
    ack   = '0;
    chk("t5_pending", 32'(pending), 32'h20);
    chk("t5_drop", 32'(drop_count), 0);
    tick(8);
    ack = 16'h0020;
    tick(1);
    ack = '0;
    chk("t5_pending_ack", 32'(pending), 0);

    // masked edge and stray ack have no effect
    ev_mask = 16'hFF7F;
    ev_in   = 16'h0080;
    ack     = 16'h0100;
    tick(1);
    ack = '0;
    tick(1);
    chk("mask_pending", 32'(pending), 0);
    chk("mask_drop", 32'(drop_count), 0);
    ev_in = '0;
    tick(4);
    ev_mask = '1;

    // 6: reset during HOLD
    ev_in = 16'h00F0;
    expect_pulse(16'h00F0, cyc + 2);
    tick(1);
    ev_in = '0;
    tick(1);
    ev_in = 16'h0010;
    tick(1);
    ev_in = '0;
    chk("t6_busy_hold", 32'(busy), 1);
    chk("t6_pending", 32'(pending), 32'hF0);
    chk("t6_drop", 32'(drop_count), 1);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_trig", 32'(trig_out), 0);
    chk("t6_rst_pending", 32'(pending), 0);
    chk("t6_rst_drop", 32'(drop_count), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick(10);
    chk("t6_post_pending", 32'(pending), 0);
    chk("t6_post_busy", 32'(busy), 0);

    tick(3);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_pulses: got %0d outstanding expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
